// File: rtl/multi_lane_occupancy_counter.sv
// Multi-lane occupancy counter.
// Each lane has a two-sensor gate (a outer, b inner) with its own direction FSM that pulses
// enter/exit only after a complete traversal. All lanes feed one saturating occupancy counter
// with full/empty status and sticky over/underflow flags.
module multi_lane_occupancy_counter #(
    parameter int unsigned LANES    = 2,
    parameter int unsigned COUNT_W  = 8,
    parameter int unsigned CAPACITY = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   a,
    input  logic [LANES-1:0]   b,
    input  logic               clr_err,
    output logic [LANES-1:0]   enter,
    output logic [LANES-1:0]   exit,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               overflow_err,
    output logic               underflow_err
);

    // Four guard bits keep count + E - X exact for up to 8 lanes, including negative results.
    localparam int unsigned SumW = COUNT_W + 4;

    typedef enum logic [2:0] {
        StIdle,
        StEn1,
        StEn2,
        StEn3,
        StEx1,
        StEx2,
        StEx3
    } lane_state_e;

    logic [LANES-1:0]   a_meta_q, a_sync_q;
    logic [LANES-1:0]   b_meta_q, b_sync_q;
    logic [LANES-1:0]   enter_d, exit_d;
    logic [LANES-1:0]   enter_q, exit_q;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [3:0]         n_enter, n_exit;
    logic [SumW-1:0]    sum;

    // Two-flop synchronisers for the asynchronous sensor inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_meta_q <= '0;
            a_sync_q <= '0;
            b_meta_q <= '0;
            b_sync_q <= '0;
        end else begin
            a_meta_q <= a;
            a_sync_q <= a_meta_q;
            b_meta_q <= b;
            b_sync_q <= b_meta_q;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_state_e state_q, state_d;
        logic        lane_enter, lane_exit;
        logic [1:0]  ab;

        assign ab = {a_sync_q[i], b_sync_q[i]};

        // Lane state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
            end else begin
                state_q <= state_d;
            end
        end

        // Direction tracking; a pulse is raised only when the last sensor clears from EN3/EX3.
        always_comb begin
            state_d    = state_q;
            lane_enter = 1'b0;
            lane_exit  = 1'b0;
            unique case (state_q)
                StIdle: begin
                    case (ab)
                        2'b10:   state_d = StEn1;
                        2'b01:   state_d = StEx1;
                        default: ;
                    endcase
                end
                StEn1: begin
                    case (ab)
                        2'b11:        state_d = StEn2;
                        2'b00, 2'b01: state_d = StIdle;
                        default:      ;
                    endcase
                end
                StEn2: begin
                    case (ab)
                        2'b01:   state_d = StEn3;
                        2'b10:   state_d = StEn1;
                        2'b00:   state_d = StIdle;
                        default: ;
                    endcase
                end
                StEn3: begin
                    case (ab)
                        2'b00: begin
                            state_d    = StIdle;
                            lane_enter = 1'b1;
                        end
                        2'b11:   state_d = StEn2;
                        2'b10:   state_d = StIdle;
                        default: ;
                    endcase
                end
                StEx1: begin
                    case (ab)
                        2'b11:        state_d = StEx2;
                        2'b00, 2'b10: state_d = StIdle;
                        default:      ;
                    endcase
                end
                StEx2: begin
                    case (ab)
                        2'b10:   state_d = StEx3;
                        2'b01:   state_d = StEx1;
                        2'b00:   state_d = StIdle;
                        default: ;
                    endcase
                end
                StEx3: begin
                    case (ab)
                        2'b00: begin
                            state_d   = StIdle;
                            lane_exit = 1'b1;
                        end
                        2'b11:   state_d = StEx2;
                        2'b01:   state_d = StIdle;
                        default: ;
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end

        assign enter_d[i] = lane_enter;
        assign exit_d[i]  = lane_exit;
    end

    // Registered one-cycle enter/exit pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enter_q <= '0;
            exit_q  <= '0;
        end else begin
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    // Population counts of this cycle's pulses.
    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int i = 0; i < LANES; i++) begin
            n_enter = n_enter + 4'(enter_q[i]);
            n_exit  = n_exit + 4'(exit_q[i]);
        end
    end

    // Net the pulses first, then saturate; a fresh error outranks clr_err.
    always_comb begin
        sum         = $unsigned($signed({4'b0000, count_q}) + $signed(SumW'(n_enter))
                                - $signed(SumW'(n_exit)));
        count_d     = sum[COUNT_W-1:0];
        overflow_d  = overflow_q & ~clr_err;
        underflow_d = underflow_q & ~clr_err;
        if (sum[SumW-1]) begin
            count_d     = '0;
            underflow_d = 1'b1;
        end else if (sum > SumW'(CAPACITY)) begin
            count_d    = COUNT_W'(CAPACITY);
            overflow_d = 1'b1;
        end
    end

    // Occupancy and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign enter         = enter_q;
    assign exit          = exit_q;
    assign count         = count_q;
    assign full          = (count_q == COUNT_W'(CAPACITY));
    assign empty         = (count_q == '0);
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: doc/multi_lane_occupancy_counter.md
Name: multi_lane_occupancy_counter

Overview:
Parametrised successor to the single-lane occupancy FSM and car counter. It supports LANES independent two-sensor (a/b) gates, each with its own direction-detecting FSM. A lane counts a passage only after a complete traversal, so aborted or backed-out passages do not count. One saturating, capacity-bounded occupancy counter aggregates all lanes and exposes full/empty status plus sticky over/underflow error flags.

Parameters:
LANES, 2, number of independent sensor-pair lanes (1..8)
COUNT_W, 8, occupancy counter width in bits
CAPACITY, 200, maximum legal occupancy (must be < 2**COUNT_W)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
a  input  LANES  outer sensor per lane, asynchronous to clk, 1 = beam blocked
b  input  LANES  inner sensor per lane, asynchronous to clk, 1 = beam blocked
clr_err  input  1  synchronous clear of sticky error flags
enter  output  LANES  one-cycle pulse per lane on a completed entry
exit  output  LANES  one-cycle pulse per lane on a completed exit
count  output  COUNT_W  current occupancy
full  output  1  count == CAPACITY
empty  output  1  count == 0
overflow_err  output  1  sticky: an entry was dropped at CAPACITY
underflow_err  output  1  sticky: an exit was dropped at 0

Behaviour:
- Reset (async, rst=1): all synchronisers 0; every lane FSM in IDLE; enter=0, exit=0, count=0, overflow_err=0, underflow_err=0; therefore empty=1, full=0.
- Input sync: each a[i] and b[i] passes through a 2-FF synchroniser. The FSMs use only the synchronised {a,b}, written ab below.
- Lane FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3. Evaluated every clock.
  - IDLE: ab=10 -> EN1; ab=01 -> EX1; else stay.
  - EN1: 11 -> EN2; 00 -> IDLE (abort); 01 -> IDLE (illegal jump); 10 stay.
  - EN2: 01 -> EN3; 10 -> EN1 (backing out); 00 -> IDLE (illegal); 11 stay.
  - EN3: 00 -> IDLE and assert enter[i]; 11 -> EN2; 10 -> IDLE (illegal); 01 stay.
  - EX1/EX2/EX3 mirror EN1/EN2/EN3 with a and b swapped. EX3 -> IDLE on 00 asserts exit[i].
- enter/exit are registered and high for exactly one cycle per completed passage. Latency is 3 rising edges from the final sensor pin edge (2 sync + 1 FSM).
- Lanes are fully independent. Any number of lanes may pulse in the same cycle.
- Counter update:
  - On the edge after the pulses, count_next = count + E - X, where E and X are popcount(enter) and popcount(exit) for that cycle.
  - Compute in signed COUNT_W+4 bits.
  - If the result > CAPACITY, count = CAPACITY and overflow_err is set.
  - If the result < 0, count = 0 and underflow_err is set.
  - Simultaneous entries and exits net out before saturation. E=X gives no change and no error.
- full and empty are decoded combinationally from count.
- clr_err clears both sticky flags on the next edge. A new error in the same cycle as clr_err wins, so the flag stays set.
- Reset mid-traversal discards the partial passage. No pulse is issued afterward, even if the sequence completes with the FSM starting from IDLE mid-pattern; e.g. the first ab after reset is 11, and IDLE ignores it.

Test Plan:
- Reset, then lane0 ab 00->10->11->01->00 with each phase held 4 cycles -> enter[0] pulses once, 1 cycle wide, 3 edges after the last edge; count=1, empty=0.
- Lane1 exit sequence 00->01->11->10->00 from count=1 -> exit[1] pulses once; count=0, empty=1, underflow_err=0.
- Lane0 00->10->11->10->00 (back-out), then 00->10->00 (abort) -> no enter pulse; count unchanged.
- Lane0 and lane1 complete entries on the same cycle from count=5 -> count=7 after one edge. Entry on lane0 plus exit on lane1 in the same cycle -> count unchanged.
- CAPACITY=3: four entries -> count=3, full=1, overflow_err=1 after the 4th. Pulse clr_err -> overflow_err=0, count stays 3.
- Assert rst while lane0 is in EN2 -> all outputs at reset values immediately. Remaining 01->00 after release -> no pulse, count=0.
